// File: rtl/qc_seq_pkg.sv
// Shared types, header bytes and width-reduction helper for the circuit sequencer.
// QC_SEQ_SATURATE_EN selects saturating reduction; otherwise results wrap.
package qc_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_STATE,
    HEADER,
    LOAD_GATE,
    COMPUTE,
    SEND
  } seq_state_t;

  localparam logic [7:0] HDR_END  = 8'h00;
  localparam logic [7:0] HDR_GATE = 8'h01;

  // Reduces v to a signed w-bit value, returned sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] v, input int w);
`ifdef QC_SEQ_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/qc_complex_mac.sv
// Serial complex multiply-accumulate: one G*S product per enabled cycle, result
// available combinationally so the last product of a row lands in the same cycle.
module qc_complex_mac
  import qc_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_QUBITS = 2,
  parameter int FRAC_W   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a_re,
  input  logic [DATA_W-1:0] i_a_im,
  input  logic [DATA_W-1:0] i_b_re,
  input  logic [DATA_W-1:0] i_b_im,
  output logic [DATA_W-1:0] o_res_re,
  output logic [DATA_W-1:0] o_res_im
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = 2 * DATA_W + N_QUBITS + 1;

  logic signed [PW-1:0] w_ac, w_bd, w_ad, w_bc;
  logic signed [AW-1:0] r_acc_re, r_acc_im;
  logic signed [AW-1:0] w_base_re, w_base_im, w_sum_re, w_sum_im, w_shr_re, w_shr_im;

  assign w_ac = $signed(i_a_re) * $signed(i_b_re);
  assign w_bd = $signed(i_a_im) * $signed(i_b_im);
  assign w_ad = $signed(i_a_re) * $signed(i_b_im);
  assign w_bc = $signed(i_a_im) * $signed(i_b_re);

  // Clear starts a new row without a separate zeroing cycle.
  assign w_base_re = i_clear ? '0 : r_acc_re;
  assign w_base_im = i_clear ? '0 : r_acc_im;
  assign w_sum_re  = w_base_re + AW'(w_ac) - AW'(w_bd);
  assign w_sum_im  = w_base_im + AW'(w_ad) + AW'(w_bc);
  assign w_shr_re  = w_sum_re >>> FRAC_W;
  assign w_shr_im  = w_sum_im >>> FRAC_W;

  assign o_res_re = DATA_W'(sat_or_wrap(64'(w_shr_re), DATA_W));
  assign o_res_im = DATA_W'(sat_or_wrap(64'(w_shr_im), DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else if (i_en) begin
      r_acc_re <= w_sum_re;
      r_acc_im <= w_sum_im;
    end
  end

endmodule

// File: rtl/qc_circuit_sequencer.sv
// Byte-stream state/gate loader, serial gate application and state streamer.
// Define QC_SEQ_SATURATE_EN for saturating result reduction (default: wrap).
//
// state      | meaning
// LOAD_STATE | receiving 2*BPC*DIM state bytes
// HEADER     | waiting for 01 (gate follows) or 00 (send state)
// LOAD_GATE  | receiving 2*BPC*DIM*DIM gate bytes, row-major
// COMPUTE    | DIM*DIM MAC cycles then one swap cycle
// SEND       | streaming current state back to host
module qc_circuit_sequencer
  import qc_seq_pkg::*;
#(
  parameter int N_QUBITS = 2,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 14,
  parameter int GCNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [GCNT_W-1:0] gate_count,
  output logic              err_hdr
);

  localparam int DIM = 1 << N_QUBITS;
  localparam int BPC = DATA_W / 8;
  localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int IW  = 2 * N_QUBITS + 1;
  localparam int RW  = N_QUBITS + 1;

  seq_state_t r_state, w_next;

  logic [DATA_W-1:0] r_state_re [DIM];
  logic [DATA_W-1:0] r_state_im [DIM];
  logic [DATA_W-1:0] r_next_re  [DIM];
  logic [DATA_W-1:0] r_next_im  [DIM];
  logic [DATA_W-1:0] r_gate_re  [DIM*DIM];
  logic [DATA_W-1:0] r_gate_im  [DIM*DIM];

  logic [BW-1:0]       r_byte;
  logic                r_part;
  logic [IW-1:0]       r_idx;
  logic [RW-1:0]       r_row;
  logic [N_QUBITS-1:0] r_col;
  logic [DATA_W-1:0]   r_asm;
  logic [7:0]          r_out_data;
  logic [GCNT_W-1:0]   r_gate_count;
  logic                r_err_hdr;

  logic                w_in_fire, w_out_fire, w_last_byte, w_amp_done;
  logic                w_last_state, w_last_gate, w_swap, w_row_end;
  logic [BW-1:0]       w_nb;
  logic                w_np;
  logic [IW-1:0]       w_ni;
  logic [DATA_W+7:0]   w_cat;
  logic [DATA_W-1:0]   w_word, w_pick_word;
  logic [7:0]          w_pick_byte;
  logic [DATA_W-1:0]   w_mac_re, w_mac_im;

  assign w_in_fire    = in_valid & in_ready;
  assign w_out_fire   = out_valid & out_ready;
  assign w_last_byte  = (r_byte == BW'(BPC - 1));
  assign w_amp_done   = w_last_byte & r_part;
  assign w_last_state = w_amp_done && (r_idx == IW'(DIM - 1));
  assign w_last_gate  = w_amp_done && (r_idx == IW'(DIM * DIM - 1));
  assign w_swap       = (r_row == RW'(DIM));
  assign w_row_end    = (r_col == N_QUBITS'(DIM - 1));

  // Byte/component/index stepping shared by the loaders and the serialiser.
  assign w_nb = w_last_byte ? '0 : r_byte + BW'(1);
  assign w_np = w_last_byte ? ~r_part : r_part;
  assign w_ni = w_amp_done ? r_idx + IW'(1) : r_idx;

  // LSB-first assembly: each new byte enters at the top and shifts down.
  assign w_cat  = {in_data, r_asm};
  assign w_word = w_cat[DATA_W+7:8];

  assign w_pick_word = w_np ? r_state_im[w_ni[N_QUBITS-1:0]] : r_state_re[w_ni[N_QUBITS-1:0]];
  assign w_pick_byte = 8'(w_pick_word >> {w_nb, 3'b000});

  qc_complex_mac #(
    .DATA_W  (DATA_W),
    .N_QUBITS(N_QUBITS),
    .FRAC_W  (FRAC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_col == '0),
    .i_en    ((r_state == COMPUTE) && !w_swap),
    .i_a_re  (r_gate_re[{r_row[N_QUBITS-1:0], r_col}]),
    .i_a_im  (r_gate_im[{r_row[N_QUBITS-1:0], r_col}]),
    .i_b_re  (r_state_re[r_col]),
    .i_b_im  (r_state_im[r_col]),
    .o_res_re(w_mac_re),
    .o_res_im(w_mac_im)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD_STATE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_STATE: if (w_in_fire && w_last_state) w_next = HEADER;
      HEADER: begin
        if (w_in_fire && in_data == HDR_GATE)     w_next = LOAD_GATE;
        else if (w_in_fire && in_data == HDR_END) w_next = SEND;
      end
      LOAD_GATE:  if (w_in_fire && w_last_gate) w_next = COMPUTE;
      COMPUTE:    if (w_swap) w_next = HEADER;
      SEND:       if (w_out_fire && w_last_state) w_next = LOAD_STATE;
      default:    w_next = LOAD_STATE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == LOAD_STATE) || (r_state == HEADER) || (r_state == LOAD_GATE);
    out_valid = (r_state == SEND);
    busy      = (r_state == COMPUTE) || (r_state == SEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte       <= '0;
      r_part       <= 1'b0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_asm        <= '0;
      r_out_data   <= '0;
      r_gate_count <= '0;
      r_err_hdr    <= 1'b0;
    end else begin
      case (r_state)
        LOAD_STATE, LOAD_GATE: begin
          if (w_in_fire) begin
            r_asm  <= w_word;
            r_byte <= w_nb;
            r_part <= w_np;
            if ((r_state == LOAD_STATE) ? w_last_state : w_last_gate) r_idx <= '0;
            else                                                      r_idx <= w_ni;
          end
        end
        HEADER: begin
          if (w_in_fire) begin
            if (in_data == HDR_END)       r_out_data <= r_state_re[0][7:0];
            else if (in_data != HDR_GATE) r_err_hdr  <= 1'b1;
          end
        end
        COMPUTE: begin
          if (w_swap) begin
            r_row <= '0;
            if (r_gate_count != '1) r_gate_count <= r_gate_count + GCNT_W'(1);
          end else begin
            r_col <= r_col + N_QUBITS'(1);
            if (w_row_end) r_row <= r_row + RW'(1);
          end
        end
        SEND: begin
          if (w_out_fire) begin
            if (w_last_state) begin
              r_byte       <= '0;
              r_part       <= 1'b0;
              r_idx        <= '0;
              r_gate_count <= '0;
            end else begin
              r_byte     <= w_nb;
              r_part     <= w_np;
              r_idx      <= w_ni;
              r_out_data <= w_pick_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers are never cleared; reset only blocks writes in its own cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == LOAD_STATE && w_in_fire && w_last_byte) begin
        if (r_part) r_state_im[r_idx[N_QUBITS-1:0]] <= w_word;
        else        r_state_re[r_idx[N_QUBITS-1:0]] <= w_word;
      end
      if (r_state == LOAD_GATE && w_in_fire && w_last_byte) begin
        if (r_part) r_gate_im[r_idx[2*N_QUBITS-1:0]] <= w_word;
        else        r_gate_re[r_idx[2*N_QUBITS-1:0]] <= w_word;
      end
      if (r_state == COMPUTE && !w_swap && w_row_end) begin
        r_next_re[r_row[N_QUBITS-1:0]] <= w_mac_re;
        r_next_im[r_row[N_QUBITS-1:0]] <= w_mac_im;
      end
      if (r_state == COMPUTE && w_swap) begin
        r_state_re <= r_next_re;
        r_state_im <= r_next_im;
      end
    end
  end

  assign out_data   = r_out_data;
  assign gate_count = r_gate_count;
  assign err_hdr    = r_err_hdr;

endmodule
